// File: rtl/reg_alu_seq.sv
// reg_alu_seq: serial command sequencer that drives a reg_alu register-file/ALU port.
// Runs one LOADI / ALU / CMP / NOP command at a time and returns the result and overflow through a response handshake.
module reg_alu_seq #(
  parameter int DASize    = 32,
  parameter int ADSize    = 5,
  parameter int OPSize    = 3,
  parameter int ALU_LAT   = 1,
  parameter int WB_ON_OVF = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_kind,
  input  logic [OPSize-1:0] cmd_op,
  input  logic [ADSize-1:0] cmd_rd,
  input  logic [ADSize-1:0] cmd_rs1,
  input  logic [ADSize-1:0] cmd_rs2,
  input  logic [DASize-1:0] cmd_imm,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DASize-1:0] rsp_data,
  output logic              rsp_ovf,
  output logic              ovf_sticky,
  input  logic              clr_ovf,
  output logic              Write,
  output logic              Read,
  output logic              S,
  output logic [DASize-1:0] DIN,
  output logic [ADSize-1:0] Write_ADDR,
  output logic [ADSize-1:0] Read_ADDR_1,
  output logic [ADSize-1:0] Read_ADDR_2,
  output logic [OPSize-1:0] OP,
  input  logic [DASize-1:0] alu_result,
  input  logic              Overflow
);

  localparam logic [1:0] KIND_LOADI = 2'b00;
  localparam logic [1:0] KIND_ALU   = 2'b01;
  localparam logic [1:0] KIND_CMP   = 2'b10;

  localparam int CW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(ALU_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOADI,
    S_EXEC,
    S_WB,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic              r_isCmp;
  logic [OPSize-1:0] r_op;
  logic [ADSize-1:0] r_rd;
  logic [ADSize-1:0] r_rs1;
  logic [ADSize-1:0] r_rs2;
  logic [DASize-1:0] r_data;
  logic              r_ovf;
  logic [CW-1:0]     r_cnt;
  logic              r_ovfSticky;

  logic w_accept;
  logic w_sample;

  assign w_accept = (r_state == S_IDLE) && cmd_valid;
  assign w_sample = (r_state == S_EXEC) && (r_cnt == '0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          case (cmd_kind)
            KIND_LOADI: w_next = S_LOADI;
            KIND_ALU:   w_next = S_EXEC;
            KIND_CMP:   w_next = S_EXEC;
            default:    w_next = S_IDLE;
          endcase
        end
      end
      S_LOADI: w_next = S_RESP;
      S_EXEC: begin
        if (r_cnt == '0) begin
          w_next = r_isCmp ? S_RESP : S_WB;
        end
      end
      S_WB:   w_next = S_RESP;
      S_RESP: begin
        if (rsp_ready) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // r_data holds the immediate for LOADI and is overwritten by the sampled ALU result otherwise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_isCmp <= 1'b0;
      r_op    <= '0;
      r_rd    <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_data  <= '0;
      r_ovf   <= 1'b0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      r_isCmp <= (cmd_kind == KIND_CMP);
      r_op    <= cmd_op;
      r_rd    <= cmd_rd;
      r_rs1   <= cmd_rs1;
      r_rs2   <= cmd_rs2;
      r_data  <= cmd_imm;
      r_ovf   <= 1'b0;
      r_cnt   <= CNT_INIT;
    end else if (w_sample) begin
      r_data  <= alu_result;
      r_ovf   <= Overflow;
    end else if (r_state == S_EXEC) begin
      r_cnt   <= r_cnt - CW'(1);
    end
  end

  // A new overflow wins over a simultaneous clear request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovfSticky <= 1'b0;
    end else if (w_sample && Overflow) begin
      r_ovfSticky <= 1'b1;
    end else if (clr_ovf) begin
      r_ovfSticky <= 1'b0;
    end
  end

  assign ovf_sticky = r_ovfSticky;

  always_comb begin
    cmd_ready   = 1'b0;
    rsp_valid   = 1'b0;
    rsp_data    = '0;
    rsp_ovf     = 1'b0;
    Write       = 1'b0;
    Read        = 1'b0;
    S           = 1'b0;
    DIN         = '0;
    Write_ADDR  = '0;
    Read_ADDR_1 = '0;
    Read_ADDR_2 = '0;
    OP          = '0;
    case (r_state)
      S_IDLE: cmd_ready = 1'b1;
      S_LOADI: begin
        Write      = 1'b1;
        DIN        = r_data;
        Write_ADDR = r_rd;
      end
      S_EXEC: begin
        Read        = 1'b1;
        Read_ADDR_1 = r_rs1;
        Read_ADDR_2 = r_rs2;
        OP          = r_op;
      end
      S_WB: begin
        Read        = 1'b1;
        Read_ADDR_1 = r_rs1;
        Read_ADDR_2 = r_rs2;
        OP          = r_op;
        S           = 1'b1;
        Write_ADDR  = r_rd;
        Write       = (WB_ON_OVF != 0) || !r_ovf;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_data  = r_data;
        rsp_ovf   = r_ovf;
      end
      default: cmd_ready = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_reg_alu_seq.sv
// Testbench for reg_alu_seq: a behavioural reg_alu stands in for the slave port, and a
// transaction-level model predicts every output cycle, checked by one compare process.
module tb_reg_alu_seq;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int OW    = 3;
  localparam int LAT   = 2;
  localparam int WBOVF = 0;

  localparam logic [1:0] K_LOADI = 2'b00;
  localparam logic [1:0] K_ALU   = 2'b01;
  localparam logic [1:0] K_CMP   = 2'b10;
  localparam logic [1:0] K_NOP   = 2'b11;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [1:0]    cmd_kind;
  logic [OW-1:0] cmd_op;
  logic [AW-1:0] cmd_rd;
  logic [AW-1:0] cmd_rs1;
  logic [AW-1:0] cmd_rs2;
  logic [DW-1:0] cmd_imm;
  logic          rsp_valid;
  logic          rsp_ready;
  logic [DW-1:0] rsp_data;
  logic          rsp_ovf;
  logic          ovf_sticky;
  logic          clr_ovf;
  logic          Write;
  logic          Read;
  logic          S;
  logic [DW-1:0] DIN;
  logic [AW-1:0] Write_ADDR;
  logic [AW-1:0] Read_ADDR_1;
  logic [AW-1:0] Read_ADDR_2;
  logic [OW-1:0] OP;
  logic [DW-1:0] alu_result;
  logic          Overflow;

  reg_alu_seq #(
    .DASize(DW), .ADSize(AW), .OPSize(OW), .ALU_LAT(LAT), .WB_ON_OVF(WBOVF)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_kind(cmd_kind), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_ovf(rsp_ovf),
    .ovf_sticky(ovf_sticky), .clr_ovf(clr_ovf),
    .Write(Write), .Read(Read), .S(S), .DIN(DIN), .Write_ADDR(Write_ADDR),
    .Read_ADDR_1(Read_ADDR_1), .Read_ADDR_2(Read_ADDR_2), .OP(OP),
    .alu_result(alu_result), .Overflow(Overflow)
  );

  always #5 clk = ~clk;

  // reg_alu behaviour: opcode 0 add, 1 sub (both signed overflow), then and/or/xor/shl/shr/pass.
  function automatic logic [DW:0] aluFn(input logic [OW-1:0] op, input logic [DW-1:0] a,
                                        input logic [DW-1:0] b);
    logic [DW-1:0] r;
    logic          v;
    r = '0;
    v = 1'b0;
    case (op)
      3'd0: begin r = a + b; v = (a[DW-1] == b[DW-1]) && (r[DW-1] != a[DW-1]); end
      3'd1: begin r = a - b; v = (a[DW-1] != b[DW-1]) && (r[DW-1] != a[DW-1]); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a << b[4:0];
      3'd6: r = a >> b[4:0];
      default: r = a;
    endcase
    return {v, r};
  endfunction

  logic [DW-1:0] envRegs [32];
  logic          envClear;
  logic [DW:0]   envAlu;

  assign envAlu     = Read ? aluFn(OP, envRegs[Read_ADDR_1], envRegs[Read_ADDR_2]) : '0;
  assign alu_result = envAlu[DW-1:0];
  assign Overflow   = envAlu[DW];

  always @(posedge clk) begin
    if (envClear) begin
      for (int i = 0; i < 32; i++) envRegs[i] <= '0;
    end else if (Write) begin
      envRegs[Write_ADDR] <= S ? alu_result : DIN;
    end
  end

  typedef struct packed {
    logic          cmdReady;
    logic          write;
    logic          read;
    logic          s;
    logic [DW-1:0] din;
    logic [AW-1:0] wa;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic [OW-1:0] op;
    logic          rspValid;
    logic [DW-1:0] rspData;
    logic          rspOvf;
    logic          sticky;
  } obs_t;

  obs_t          expQ [$];
  string         tagQ [$];
  logic [DW-1:0] mRegs [32];
  bit            mSticky;
  bit            chkEn;
  int            checks;
  int            errors;
  logic [DW-1:0] lastRspData;
  logic          lastRspOvf;
  obs_t          cmpWant;
  string         cmpTag;

  function automatic obs_t busyObs(input bit st);
    obs_t o;
    o = '0;
    o.sticky = st;
    return o;
  endfunction

  function automatic obs_t idleObs(input bit st);
    obs_t o;
    o = busyObs(st);
    o.cmdReady = 1'b1;
    return o;
  endfunction

  function automatic obs_t getObs();
    obs_t o;
    o.cmdReady = cmd_ready;  o.write = Write;       o.read = Read;         o.s = S;
    o.din = DIN;             o.wa = Write_ADDR;     o.ra1 = Read_ADDR_1;   o.ra2 = Read_ADDR_2;
    o.op = OP;               o.rspValid = rsp_valid; o.rspData = rsp_data; o.rspOvf = rsp_ovf;
    o.sticky = ovf_sticky;
    return o;
  endfunction

  function automatic string fmtObs(input obs_t o);
    return $sformatf("cr=%b w=%b r=%b s=%b din=%h wa=%0d ra1=%0d ra2=%0d op=%0d rv=%b rd=%h ro=%b st=%b",
                     o.cmdReady, o.write, o.read, o.s, o.din, o.wa, o.ra1, o.ra2, o.op,
                     o.rspValid, o.rspData, o.rspOvf, o.sticky);
  endfunction

  task automatic checkOutput(input string tag, input obs_t got, input obs_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s @%0t: got {%s} expected {%s}", tag, $time, fmtObs(got), fmtObs(want));
    end
  endtask

  task automatic checkValue(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("[TB] FAIL %s @%0t: got %h expected %h", tag, $time, got, want);
    end
  endtask

  // Every cycle the bench is in sync with the DUT, compare against the predicted cycle or idle.
  always @(negedge clk) begin
    if (chkEn) begin
      if (expQ.size() > 0) begin
        cmpWant = expQ.pop_front();
        cmpTag  = tagQ.pop_front();
      end else begin
        cmpWant = idleObs(mSticky);
        cmpTag  = "idle";
      end
      checkOutput(cmpTag, getObs(), cmpWant);
    end
  end

  task automatic idleCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic clearSticky();
    clr_ovf = 1'b1;
    @(posedge clk);
    #1;
    clr_ovf = 1'b0;
    mSticky = 1'b0;
  endtask

  // Issues one command (called #1 after an edge with the DUT idle) and runs it to its handshake.
  task automatic applyStimulus(input logic [1:0] kind, input logic [OW-1:0] op,
                               input logic [AW-1:0] rd, input logic [AW-1:0] rs1,
                               input logic [AW-1:0] rs2, input logic [DW-1:0] imm,
                               input int rspDelay, input bit clrAtSample);
    obs_t          e;
    logic [DW:0]   r;
    logic [DW-1:0] res;
    logic          ovf;
    bit            newSt;
    int            busy;
    cmd_kind  = kind;
    cmd_op    = op;
    cmd_rd    = rd;
    cmd_rs1   = rs1;
    cmd_rs2   = rs2;
    cmd_imm   = imm;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_imm   = $urandom();
    cmd_rd    = AW'($urandom());
    cmd_rs1   = AW'($urandom());
    cmd_rs2   = AW'($urandom());
    cmd_op    = OW'($urandom());
    if (kind == K_NOP) return;
    newSt = mSticky;
    if (kind == K_LOADI) begin
      e = busyObs(mSticky);
      e.write = 1'b1; e.din = imm; e.wa = rd;
      expQ.push_back(e); tagQ.push_back("loadi write");
      mRegs[rd] = imm;
      res  = imm;
      ovf  = 1'b0;
      busy = 1;
    end else begin
      r   = aluFn(op, mRegs[rs1], mRegs[rs2]);
      res = r[DW-1:0];
      ovf = r[DW];
      for (int i = 0; i < LAT; i++) begin
        e = busyObs(mSticky);
        e.read = 1'b1; e.ra1 = rs1; e.ra2 = rs2; e.op = op;
        expQ.push_back(e); tagQ.push_back("exec");
      end
      newSt = ovf ? 1'b1 : (clrAtSample ? 1'b0 : mSticky);
      busy  = LAT;
      if (kind == K_ALU) begin
        e = busyObs(newSt);
        e.read = 1'b1; e.ra1 = rs1; e.ra2 = rs2; e.op = op;
        e.s = 1'b1; e.wa = rd; e.write = (WBOVF != 0) || !ovf;
        expQ.push_back(e); tagQ.push_back("writeback");
        if (e.write) mRegs[rd] = res;
        busy = LAT + 1;
      end
    end
    for (int i = 0; i <= rspDelay; i++) begin
      e = busyObs(newSt);
      e.rspValid = 1'b1; e.rspData = res; e.rspOvf = ovf;
      expQ.push_back(e); tagQ.push_back("response");
    end
    for (int c = 0; c < busy; c++) begin
      if (clrAtSample && kind != K_LOADI && c == LAT - 1) clr_ovf = 1'b1;
      @(posedge clk);
      #1;
      clr_ovf = 1'b0;
    end
    mSticky = newSt;
    repeat (rspDelay) idleCycle();
    lastRspData = rsp_data;
    lastRspOvf  = rsp_ovf;
    rsp_ready   = 1'b1;
    @(posedge clk);
    #1;
    rsp_ready   = 1'b0;
  endtask

  initial begin
    logic [1:0]    kind;
    logic [DW-1:0] imm;
    checks    = 0;
    errors    = 0;
    chkEn     = 1'b0;
    mSticky   = 1'b0;
    rst       = 1'b1;
    envClear  = 1'b1;
    cmd_valid = 1'b0;
    cmd_kind  = '0;
    cmd_op    = '0;
    cmd_rd    = '0;
    cmd_rs1   = '0;
    cmd_rs2   = '0;
    cmd_imm   = '0;
    rsp_ready = 1'b0;
    clr_ovf   = 1'b0;
    for (int i = 0; i < 32; i++) mRegs[i] = '0;
    #1;
    checkOutput("reset state", getObs(), idleObs(1'b0));
    @(posedge clk);
    #1;
    rst      = 1'b0;
    envClear = 1'b0;
    chkEn    = 1'b1;

    $display("[TB] directed loads and add");
    applyStimulus(K_LOADI, 3'd0, 5'd0, 5'd0, 5'd0, 32'h0000_000F, 0, 1'b0);
    checkValue("loadi r0 rsp_data", lastRspData, 32'h0000_000F);
    applyStimulus(K_LOADI, 3'd0, 5'd1, 5'd0, 5'd0, 32'h0000_0001, 0, 1'b0);
    applyStimulus(K_LOADI, 3'd0, 5'd2, 5'd0, 5'd0, 32'h0000_0002, 0, 1'b0);
    applyStimulus(K_ALU, 3'd0, 5'd3, 5'd1, 5'd2, 32'h0, 0, 1'b0);
    checkValue("add r3 rsp_data", lastRspData, 32'h0000_0003);
    checkValue("add r3 rsp_ovf", DW'(lastRspOvf), 32'h0);
    checkValue("add r3 regfile", envRegs[3], 32'h0000_0003);

    $display("[TB] overflow suppression and sticky flag");
    applyStimulus(K_LOADI, 3'd0, 5'd1, 5'd0, 5'd0, 32'h7FFF_FFFF, 0, 1'b0);
    applyStimulus(K_LOADI, 3'd0, 5'd2, 5'd0, 5'd0, 32'h0000_0001, 0, 1'b0);
    applyStimulus(K_ALU, 3'd0, 5'd4, 5'd1, 5'd2, 32'h0, 0, 1'b0);
    checkValue("ovf add rsp_data", lastRspData, 32'h8000_0000);
    checkValue("ovf add rsp_ovf", DW'(lastRspOvf), 32'h1);
    checkValue("ovf add sticky", DW'(ovf_sticky), 32'h1);
    checkValue("ovf add no write", envRegs[4], 32'h0);
    clearSticky();
    checkValue("sticky cleared", DW'(ovf_sticky), 32'h0);
    applyStimulus(K_ALU, 3'd0, 5'd5, 5'd1, 5'd2, 32'h0, 0, 1'b1);
    checkValue("set beats clear", DW'(ovf_sticky), 32'h1);

    $display("[TB] held response, compare, nop");
    applyStimulus(K_CMP, 3'd1, 5'd6, 5'd1, 5'd2, 32'h0, 5, 1'b0);
    checkValue("cmp sub rsp_data", lastRspData, 32'h7FFF_FFFE);
    checkValue("cmp no write", envRegs[6], 32'h0);
    applyStimulus(K_NOP, 3'd0, 5'd7, 5'd1, 5'd2, 32'hDEAD_BEEF, 0, 1'b0);
    idleCycle();
    idleCycle();

    $display("[TB] reset during exec");
    chkEn     = 1'b0;
    cmd_kind  = K_ALU;
    cmd_op    = 3'd3;
    cmd_rd    = 5'd7;
    cmd_rs1   = 5'd1;
    cmd_rs2   = 5'd2;
    cmd_valid = 1'b1;
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    checkValue("exec read before reset", DW'(Read), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("reset mid exec", getObs(), idleObs(1'b0));
    @(posedge clk);
    #1;
    rst     = 1'b0;
    mSticky = 1'b0;
    chkEn   = 1'b1;
    applyStimulus(K_LOADI, 3'd0, 5'd8, 5'd0, 5'd0, 32'h0000_1234, 1, 1'b0);
    checkValue("loadi after reset", lastRspData, 32'h0000_1234);
    checkValue("aborted write dropped", envRegs[7], 32'h0);

    $display("[TB] randomized commands");
    for (int n = 0; n < 80; n++) begin
      kind = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 4))
        0: imm = 32'h7FFF_FFFF;
        1: imm = 32'h8000_0000;
        2: imm = 32'hFFFF_FFFF;
        default: imm = $urandom();
      endcase
      applyStimulus(kind, OW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)),
                    AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)), imm,
                    int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0));
      repeat ($urandom_range(0, 2)) idleCycle();
      if ($urandom_range(0, 9) == 0) clearSticky();
    end

    idleCycle();
    chkEn = 1'b0;
    for (int i = 0; i < 32; i++) begin
      checkValue($sformatf("regfile r%0d", i), envRegs[i], mRegs[i]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
